// File: rtl/baby_loader_pkg.sv
// Shared types and constants for the Baby byte-stream program loader.
package baby_loader_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int DWIDTH_DEFAULT = 32;
  localparam int BYTES_PER_WORD = DWIDTH_DEFAULT / 8;

  function automatic int bytes_per_word(input int dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/baby_word_assembler.sv
// Little-endian word assembler: one byte per load, byte_idx wraps after the last byte.
module baby_word_assembler
  import baby_loader_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [7:0]        byte_in,
  output logic [DWIDTH-1:0] word_next,
  output logic              word_full
);

  localparam int BPW = bytes_per_word(DWIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0]     idx_q, idx_d;
  logic [DWIDTH-1:0] word_q, word_d;

  // word_next already contains the incoming byte, so the last byte of a word
  // can be forwarded to the store without an extra cycle.
  always_comb begin
    word_next = word_q;
    word_next[idx_q*8 +: 8] = byte_in;
    word_full = (idx_q == IW'(BPW - 1));
    word_d    = word_q;
    idx_d     = idx_q;
    if (clr) begin
      word_d = '0;
      idx_d  = '0;
    end else if (load) begin
      word_d = word_next;
      idx_d  = word_full ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/baby_loader.sv
// Framed byte-stream loader for the Baby store; holds the CPU in reset until loaded.
// Define BABY_LOADER_CKSUM_EN to require a trailing XOR checksum byte per frame.
module baby_loader
  import baby_loader_pkg::*;
#(
  parameter int         DWIDTH    = DWIDTH_DEFAULT,
  parameter int         AWIDTH    = 5,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_a,
  output logic [DWIDTH-1:0] mem_d,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [AWIDTH:0]   words_mon
);

  state_t            state_q, state_d;
  logic [AWIDTH:0]   n_q, n_d;
  logic [AWIDTH:0]   words_q, words_d;
  logic [AWIDTH-1:0] mem_a_q, mem_a_d;
  logic [DWIDTH-1:0] mem_d_q, mem_d_d;
  logic              accept, count_bad;
  logic              asm_clr, asm_load, asm_full;
  logic [DWIDTH-1:0] asm_word;
`ifdef BABY_LOADER_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  baby_word_assembler #(.DWIDTH(DWIDTH)) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (asm_clr),
    .load     (asm_load),
    .byte_in  (in_data),
    .word_next(asm_word),
    .word_full(asm_full)
  );

  assign accept    = in_valid && in_ready;
  assign count_bad = (in_data == 8'd0) || (32'(in_data) > (32'd1 << AWIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SYNC;
      n_q     <= '0;
      words_q <= '0;
      mem_a_q <= '0;
      mem_d_q <= '0;
`ifdef BABY_LOADER_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      words_q <= words_d;
      mem_a_q <= mem_a_d;
      mem_d_q <= mem_d_d;
`ifdef BABY_LOADER_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    words_d  = words_q;
    mem_a_d  = mem_a_q;
    mem_d_d  = mem_d_q;
    asm_clr  = 1'b0;
    asm_load = 1'b0;
`ifdef BABY_LOADER_CKSUM_EN
    cksum_d  = cksum_q;
`endif
    case (state_q)
      S_SYNC: if (accept && in_data == SYNC_BYTE) state_d = S_COUNT;
      S_COUNT: begin
        if (accept) begin
          if (count_bad) begin
            state_d = S_ERR;
          end else begin
            n_d     = (AWIDTH+1)'(in_data);
            words_d = '0;
            asm_clr = 1'b1;
`ifdef BABY_LOADER_CKSUM_EN
            cksum_d = '0;
`endif
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_load = 1'b1;
`ifdef BABY_LOADER_CKSUM_EN
          cksum_d  = cksum_q ^ in_data;
`endif
          if (asm_full) begin
            mem_a_d = words_q[AWIDTH-1:0];
            mem_d_d = asm_word;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + 1'b1;
`ifdef BABY_LOADER_CKSUM_EN
        state_d = (words_d == n_q) ? S_CKSUM : S_DATA;
`else
        state_d = (words_d == n_q) ? S_DONE : S_DATA;
`endif
      end
`ifdef BABY_LOADER_CKSUM_EN
      S_CKSUM: if (accept) state_d = (in_data == cksum_q) ? S_DONE : S_ERR;
`endif
      S_DONE: state_d = S_DONE;
      S_ERR: begin
        if (accept && in_data == SYNC_BYTE) begin
          words_d = '0;
          state_d = S_COUNT;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != S_WRITE) && (state_q != S_DONE);
    mem_we    = (state_q == S_WRITE);
    cpu_hold  = (state_q != S_DONE);
    done      = (state_q == S_DONE);
    err       = (state_q == S_ERR);
    mem_a     = mem_a_q;
    mem_d     = mem_d_q;
    words_mon = words_q;
  end

endmodule

// File: tb/tb_baby_loader.sv
// Self-checking bench for baby_loader: directed frames with random payloads and gaps.
module tb_baby_loader;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef BABY_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, mem_we, cpu_hold, done, err;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [AW:0]   words_mon;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_cyc = -1;
  wr_t obs[$];
  logic [DW-1:0] store[0:(1<<AW)-1];

  baby_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .words_mon(words_mon)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs.push_back('{mem_a, mem_d, cyc});
      store[mem_a] = mem_d;
      chk("ready_low_in_write", 64'(in_ready), 64'd0);
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  function automatic logic [7:0] xor_of(input bq_t data);
    logic [7:0] x = 8'h00;
    foreach (data[i]) x ^= data[i];
    return x;
  endfunction

  function automatic bq_t make_frame(input int n, input bq_t data);
    bq_t f;
    f.push_back(8'hA5);
    f.push_back(8'(n));
    foreach (data[i]) f.push_back(data[i]);
    if (CK) f.push_back(xor_of(data));
    return f;
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat ($urandom_range(0, gap)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && t <= 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 64'(t > 50), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input bq_t s, input int gap);
    foreach (s[i]) send_byte(s[i], gap);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag, input bq_t data);
    int n = data.size() / 4;
    chk({tag, "_nwrites"}, 64'(obs.size()), 64'(n));
    for (int k = 0; k < n && k < obs.size(); k++) begin
      logic [DW-1:0] w = '0;
      for (int j = 0; j < 4; j++) w |= DW'(data[4*k+j]) << (8*j);
      chk({tag, "_addr"}, 64'(obs[k].a), 64'(k));
      chk({tag, "_data"}, 64'(obs[k].d), 64'(w));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs.delete();
    done_cyc = -1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_a"}, 64'(mem_a), 64'd0);
    chk({tag, "_mem_d"}, 64'(mem_d), 64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_words_mon"}, 64'(words_mon), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s, d;
    int  idle_bad;

    do_reset();
    @(negedge clk);
    chk_reset_outputs("reset");

    // Idle after reset.
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!(cpu_hold === 1'b1 && in_ready === 1'b1 && done === 1'b0 && mem_we === 1'b0)) idle_bad++;
    end
    chk("idle_flags", 64'(idle_bad), 64'd0);
    chk("idle_writes", 64'(obs.size()), 64'd0);
    @(posedge clk);
    #1;

    // Leading junk, two-word frame, then a trailing byte that must be refused.
    d = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    s = make_frame(2, d);
    s.push_front(8'h00);
    s.push_front(8'h13);
    send(s, 0);
    check_writes("two_word", d);
    if (obs.size() >= 2) chk("done_latency", 64'(done_cyc), 64'(obs[1].cyc + 1));
    chk("two_word_done", 64'(done), 64'd1);
    chk("two_word_hold", 64'(cpu_hold), 64'd0);
    chk("two_word_ready", 64'(in_ready), 64'd0);
    chk("two_word_words", 64'(words_mon), 64'd2);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("trailing_writes", 64'(obs.size()), 64'd2);
    chk("trailing_done", 64'(done), 64'd1);

    // Bad counts then recovery.
    do_reset();
    send('{8'hA5, 8'h00}, 0);
    chk("count0_err", 64'(err), 64'd1);
    chk("count0_hold", 64'(cpu_hold), 64'd1);
    send('{8'hA5, 8'h21}, 0);
    chk("count33_err", 64'(err), 64'd1);
    chk("bad_count_writes", 64'(obs.size()), 64'd0);
    d = '{8'h04, 8'h03, 8'h02, 8'h01};
    send(make_frame(1, d), 0);
    check_writes("recover", d);
    chk("recover_err", 64'(err), 64'd0);
    chk("recover_done", 64'(done), 64'd1);

    // Full image with random gaps.
    do_reset();
    d = {};
    for (int i = 0; i < 128; i++) d.push_back(8'($urandom));
    send(make_frame(32, d), 3);
    check_writes("full", d);
    chk("full_words", 64'(words_mon), 64'd32);
    chk("full_done", 64'(done), 64'd1);

`ifdef BABY_LOADER_CKSUM_EN
    do_reset();
    send('{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}, 1);
    chk("ck_good_done", 64'(done), 64'd1);
    chk("ck_good_err", 64'(err), 64'd0);
    do_reset();
    send('{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45}, 1);
    chk("ck_bad_err", 64'(err), 64'd1);
    chk("ck_bad_hold", 64'(cpu_hold), 64'd1);
    chk("ck_bad_done", 64'(done), 64'd0);
    chk("ck_bad_store0", 64'(store[0]), 64'h44332211);
`endif

    // Reset pulse mid-frame, then a clean reload.
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    chk("midrst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs.delete();
    d = {};
    for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
    send(make_frame(3, d), 2);
    check_writes("after_rst", d);
    chk("after_rst_done", 64'(done), 64'd1);
    chk("after_rst_words", 64'(words_mon), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baby_loader.md
Name: baby_loader

Overview:
- Byte-stream program loader upstream of the Baby store and CPU.
- Receives a framed image on a valid/ready byte interface and assembles little-endian words.
- Writes each word into the store through a dedicated write port.
- Holds the CPU in reset until the whole image is written. The `done` output releases the machine to start at line 0.

Parameters:
- DWIDTH, 32, store word width in bits; multiple of 8.
- AWIDTH, 5, store address width; the image holds at most 2**AWIDTH words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  loader can accept a byte.
- in_data  input  8  upstream byte.
- mem_we  output  1  store write enable, one-cycle pulse per word.
- mem_a  output  AWIDTH  store write address.
- mem_d  output  DWIDTH  store write data.
- cpu_hold  output  1  high keeps the CPU in reset.
- done  output  1  image fully loaded; sticky.
- err  output  1  framing or checksum error.
- words_mon  output  AWIDTH+1  words written so far.

Behaviour:
- Reset values: mem_we=0, mem_a=0, mem_d=0, cpu_hold=1, done=0, err=0, words_mon=0. The FSM resets to SYNC.
- Byte acceptance:
  - A byte is accepted only on a cycle where in_valid && in_ready.
  - in_ready is a decode of state only: 1 in SYNC, COUNT, DATA, CKSUM and ERR; 0 in WRITE and DONE.
- Frame format: SYNC_BYTE, then N (1..2**AWIDTH), then N*DWIDTH/8 data bytes with the least significant byte first, then an optional checksum byte.
- FSM states and transitions:
  - SYNC: bytes other than SYNC_BYTE are discarded. SYNC_BYTE moves to COUNT.
  - COUNT: latch N. If N==0 or N>2**AWIDTH, go to ERR; otherwise clear the byte counter, address and checksum, then go to DATA.
  - DATA:
    - Each accepted byte is shifted into the word at position byte_idx*8. byte_idx counts up to DWIDTH/8-1 and then wraps to 0.
    - When the last byte of a word is accepted, go to WRITE.
  - WRITE:
    - Exactly one cycle: mem_we=1, mem_a=current address, mem_d=assembled word.
    - On exit, increment the address and words_mon.
    - If words_mon now equals N, go to CKSUM (feature on) or DONE (feature off); otherwise return to DATA.
  - DONE: done=1 and cpu_hold=0 from the first DONE cycle. Further bytes are not accepted. Leaving DONE requires reset.
  - ERR:
    - err=1, cpu_hold stays 1, no writes.
    - Accepted bytes other than SYNC_BYTE are discarded.
    - SYNC_BYTE clears err, resets words_mon and goes to COUNT.
- mem_a/mem_d hold their last value when mem_we=0. mem_we is never high outside WRITE.
- Address does not wrap within a frame, because N is bounded.
- Ordering: a write of word k completes before byte 0 of word k+1 can be accepted.
- in_valid gaps of any length in any state: no state change, no data loss.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Words already written stay in the store.
- The loader never reads the store.

Optional Feature:
- Macro: BABY_LOADER_CKSUM_EN.
- With it:
  - A running XOR of all data bytes is kept.
  - After the Nth WRITE the FSM enters CKSUM and accepts one byte.
  - Match → DONE; mismatch → ERR.
  - Words already written remain in the store, but cpu_hold stays 1.
- Without it: the CKSUM state and the XOR register are absent. The last WRITE goes straight to DONE. A trailing byte after a frame is not accepted.

Decomposition:
- Package baby_loader_pkg holds:
  - the state enum (SYNC, COUNT, DATA, WRITE, CKSUM, DONE, ERR);
  - the default SYNC_BYTE;
  - BYTES_PER_WORD = DWIDTH/8.
- One sub-module, baby_word_assembler: a byte shift register plus byte_idx counter, with load/clear inputs and a word_full output.

Test Plan:
- Reset then idle: cpu_hold=1, in_ready=1, mem_we never pulses, done=0 for 100 cycles.
- Stream 13 00 A5 02 01 00 00 00 FF FF FF FF with the feature off:
  - the first two bytes are dropped;
  - writes go to addr0=0x00000001 and addr1=0xFFFFFFFF, two mem_we pulses;
  - done=1 and cpu_hold=0 one cycle after the second write;
  - in_ready=0 thereafter.
- Bad count A5 00 and A5 21:
  - err=1 and no mem_we in each case;
  - a following A5 01 04 03 02 01 writes 0x01020304 to addr0 and clears err.
- Full image A5 20 followed by 128 bytes, with random in_valid gaps:
  - 32 writes to addr 0..31 in order with the correct data;
  - in_ready=0 during each WRITE cycle;
  - words_mon=32.
- BABY_LOADER_CKSUM_EN, frame A5 01 11 22 33 44:
  - checksum 44 → done=1 (11^22^33^44 = 44);
  - checksum 45 → err=1, cpu_hold=1, addr0 still holds 0x44332211.
- rst_n low for one cycle after the third data byte: all outputs return to reset values, and the next full frame loads correctly.
